// File: rtl/vai_tx_c0_arbiter.sv
// vai_tx_c0_arbiter: round-robin scheduler that drains the per-sub-AFU c0
// read-request FIFOs onto the single upstream c0 port. When BATCH_LEN > 1 it
// keeps the grant on one AFU for up to BATCH_LEN back-to-back pops.

// One requester lane: eligibility, pop strobe and the AND-OR data mux term.
module vai_tx_c0_lane #(
   parameter int DATA_WIDTH = 64,
   parameter int LNUM       = 3,
   parameter int IDX        = 0
) (
   input  logic                  need_rd,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [LNUM-1:0]       sel,
   input  logic                  go,
   output logic                  eligible,
   output logic                  rd_req,
   output logic [DATA_WIDTH-1:0] data_m
);
   logic hit;
   assign hit      = (sel == LNUM'(IDX));
   assign eligible = need_rd & enable;
   assign rd_req   = go & hit;
   assign data_m   = hit ? data : '0;
endmodule

module vai_tx_c0_arbiter #(
   parameter int NUM_SUB_AFUS = 8,
   parameter int DATA_WIDTH   = 64,
   parameter int BATCH_LEN    = 4,
   localparam int LNUM = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_SUB_AFUS-1:0]          fifo_need_rd,
   input  logic [NUM_SUB_AFUS*DATA_WIDTH-1:0] fifo_data,
   output logic [NUM_SUB_AFUS-1:0]          fifo_rd_req,
   input  logic [NUM_SUB_AFUS-1:0]          afu_enable,
   input  logic                             up_alm_full,
   output logic                             tx_valid,
   output logic [DATA_WIDTH-1:0]            tx_data,
   output logic [LNUM-1:0]                  tx_vmid,
   output logic [1:0]                       arb_state
);
   localparam int CW = (BATCH_LEN > 1) ? $clog2(BATCH_LEN + 1) : 1;

   typedef enum logic [1:0] {
      READ_NORMAL = 2'd0,
      READ_BATCH  = 2'd1
   } state_t;

   state_t          state, state_n;
   logic [LNUM-1:0] rr_ptr, rr_n, cur, cur_n, sel_rr, sel;
   logic [CW-1:0]   cnt, cnt_n;
   logic            go;
   logic [NUM_SUB_AFUS-1:0]                 eligible;
   logic [NUM_SUB_AFUS-1:0][DATA_WIDTH-1:0] data_m;
   logic [DATA_WIDTH-1:0]                   head_data;

   for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_lane
      vai_tx_c0_lane #(.DATA_WIDTH(DATA_WIDTH), .LNUM(LNUM), .IDX(i)) u_lane (
         .need_rd  (fifo_need_rd[i]),
         .enable   (afu_enable[i]),
         .data     (fifo_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .sel      (sel),
         .go       (go),
         .eligible (eligible[i]),
         .rd_req   (fifo_rd_req[i]),
         .data_m   (data_m[i])
      );
   end

   // First eligible index at or after rr_ptr, wrapping at NUM_SUB_AFUS (not 2**LNUM).
   always_comb begin
      int idx;
      logic found;
      sel_rr = rr_ptr;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_SUB_AFUS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_SUB_AFUS) idx = idx - NUM_SUB_AFUS;
         if (!found && eligible[idx]) begin
            sel_rr = LNUM'(idx);
            found  = 1'b1;
         end
      end
   end

   // Grant decision; reset gating keeps every pop strobe low while in reset.
   assign sel = (state == READ_BATCH) ? cur : sel_rr;
   assign go  = reset_n & ~up_alm_full & eligible[sel];

   // Head entry of the selected FIFO (one-hot AND-OR mux across lanes).
   always_comb begin
      head_data = '0;
      for (int i = 0; i < NUM_SUB_AFUS; i++) head_data = head_data | data_m[i];
   end

   // Next-state: round-robin pointer advance, batch entry/exit and pop counting.
   always_comb begin
      state_n = state;
      rr_n    = rr_ptr;
      cur_n   = cur;
      cnt_n   = cnt;
      case (state)
         READ_NORMAL: begin
            if (go) begin
               rr_n = (sel_rr == LNUM'(NUM_SUB_AFUS - 1)) ? '0 : sel_rr + 1'b1;
               if (BATCH_LEN > 1) begin
                  cur_n   = sel_rr;
                  cnt_n   = CW'(1);
                  state_n = READ_BATCH;
               end
            end
         end
         READ_BATCH: begin
            if (!eligible[cur]) begin
               // Drained or disabled: give up the grant, costs one bubble.
               state_n = READ_NORMAL;
               cnt_n   = '0;
            end else if (go) begin
               if (cnt == CW'(BATCH_LEN - 1)) begin
                  state_n = READ_NORMAL;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: state_n = READ_NORMAL;
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= READ_NORMAL;
         rr_ptr <= '0;
         cur    <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_n;
         cur    <= cur_n;
         cnt    <= cnt_n;
      end
   end

   // Output register: one cycle after the pop strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_vmid  <= '0;
      end else begin
         tx_valid <= go;
         if (go) begin
            tx_data <= head_data;
            tx_vmid <= sel;
         end
      end
   end

   assign arb_state = state;
endmodule
